// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad cascade: tap indices, FSM
// encoding, default widths and the round/saturate helper.
package iir_pkg;

    localparam int unsigned DefDw   = 24;
    localparam int unsigned DefFw   = 22;
    localparam int unsigned NumTaps = 5;

    // Coefficient slot order inside one section.
    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StWb   = 2'd2,
        StOut  = 2'd3
    } state_e;

    // Helper works on a fixed wide container so it can serve any DW/FW combination.
    localparam int unsigned AccMaxW = 128;
    localparam int unsigned ResMaxW = 64;

    typedef struct packed {
        logic                  sat;
        logic [ResMaxW-1:0]    val;
    } sat_res_t;

    // Round half up at bit FW, then clamp to a signed DW-bit range.
    function automatic sat_res_t sat_round(input logic signed [AccMaxW-1:0] acc,
                                           input int unsigned dw,
                                           input int unsigned fw);
        logic signed [AccMaxW-1:0] one;
        logic signed [AccMaxW-1:0] half;
        logic signed [AccMaxW-1:0] rnd;
        logic signed [AccMaxW-1:0] max_v;
        logic signed [AccMaxW-1:0] min_v;
        sat_res_t                  res;
        one   = AccMaxW'(1);
        half  = one <<< (fw - 1);
        rnd   = (acc + half) >>> fw;
        max_v = (one <<< (dw - 1)) - one;
        min_v = -(one <<< (dw - 1));
        res.sat = 1'b0;
        res.val = rnd[ResMaxW-1:0];
        if (rnd > max_v) begin
            res.sat = 1'b1;
            res.val = max_v[ResMaxW-1:0];
        end else if (rnd < min_v) begin
            res.sat = 1'b1;
            res.val = min_v[ResMaxW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Shared multiply-accumulate engine: signed product added or subtracted into a
// full-precision accumulator, with a combinational rounded/saturated result.
module iir_mac_sat
    import iir_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned FW = DefFw
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 sub_i,
    input  logic signed [DW-1:0] coef_i,
    input  logic signed [DW-1:0] opnd_i,
    output logic [DW-1:0]        res_o,
    output logic                 sat_o
);

    localparam int unsigned AccW = 2 * DW + 3;

    logic signed [AccW-1:0]   acc_q;
    logic signed [AccW-1:0]   acc_d;
    logic signed [2*DW-1:0]   prod;
    sat_res_t                 rnd;
    logic                     unused_rnd_hi;

    assign prod = coef_i * opnd_i;

    // Accumulator next state: clear has priority, feedback taps subtract.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            if (sub_i) begin
                acc_d = acc_q - AccW'(prod);
            end else begin
                acc_d = acc_q + AccW'(prod);
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Quantise the accumulator back to the sample format.
    always_comb begin
        rnd           = sat_round(AccMaxW'(acc_q), DW, FW);
        res_o         = rnd.val[DW-1:0];
        sat_o         = rnd.sat;
        unused_rnd_hi = ^rnd.val[ResMaxW-1:DW];
    end

endmodule

// File: rtl/iir_sos_cascade_tdm.sv
// Cascade of NUM_SECT direct-form-I biquads sharing one MAC. Each accepted sample
// walks through every section (5 MAC cycles + 1 write-back each) before it is
// offered downstream; coefficients are loadable at run time while idle.
module iir_sos_cascade_tdm
    import iir_pkg::*;
#(
    parameter int unsigned DW       = DefDw,
    parameter int unsigned FW       = DefFw,
    parameter int unsigned NUM_SECT = 4,
    localparam int unsigned AW      = $clog2(NUM_SECT * 5)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    input  logic          cfg_we_i,
    input  logic [AW-1:0] cfg_addr_i,
    input  logic [DW-1:0] cfg_wdata_i,
    output logic          cfg_err_o,
    input  logic          clear_state_i,
    output logic          sat_flag_o
);

    localparam int unsigned NumCoef = NUM_SECT * NumTaps;
    localparam int unsigned SecW    = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;

    state_e          state_q, state_d;
    logic [SecW-1:0] sec_q, sec_d;
    logic [2:0]      tap_q, tap_d;
    logic [DW-1:0]   x_q, x_d;
    logic [DW-1:0]   out_q, out_d;
    logic            sat_q, sat_d;
    logic            cfg_err_q, cfg_err_d;

    logic [DW-1:0]   coef_q [NumCoef];
    logic [DW-1:0]   x1_q   [NUM_SECT];
    logic [DW-1:0]   x2_q   [NUM_SECT];
    logic [DW-1:0]   y1_q   [NUM_SECT];
    logic [DW-1:0]   y2_q   [NUM_SECT];

    logic [AW-1:0]   coef_idx;
    logic [DW-1:0]   mac_coef;
    logic [DW-1:0]   mac_opnd;
    logic            mac_sub;
    logic            mac_en;
    logic            mac_clr;
    logic [DW-1:0]   mac_res;
    logic            mac_sat;
    logic            cfg_addr_ok;
    logic            cfg_wr;
    logic            clear_now;

    assign cfg_addr_ok = 32'(cfg_addr_i) < NumCoef;
    assign cfg_wr      = cfg_we_i && (state_q == StIdle) && cfg_addr_ok;
    assign cfg_err_d   = cfg_we_i && !cfg_wr;
    assign clear_now   = (state_q == StIdle) && clear_state_i;

    assign mac_en      = (state_q == StMac);
    assign mac_clr     = (state_q != StMac);
    assign coef_idx    = AW'(sec_q) * AW'(NumTaps) + AW'(tap_q);
    assign mac_coef    = coef_q[coef_idx];

    assign out_data_o  = out_q;
    assign cfg_err_o   = cfg_err_q;
    assign sat_flag_o  = sat_q;

    // Pick the delay-line operand for the current tap; feedback taps subtract.
    always_comb begin
        mac_opnd = '0;
        mac_sub  = 1'b0;
        case (tap_q)
            TAP_B0: mac_opnd = x_q;
            TAP_B1: mac_opnd = x1_q[sec_q];
            TAP_B2: mac_opnd = x2_q[sec_q];
            TAP_A1: begin
                mac_opnd = y1_q[sec_q];
                mac_sub  = 1'b1;
            end
            TAP_A2: begin
                mac_opnd = y2_q[sec_q];
                mac_sub  = 1'b1;
            end
            default: mac_opnd = '0;
        endcase
    end

    iir_mac_sat #(
        .DW (DW),
        .FW (FW)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .sub_i  (mac_sub),
        .coef_i (mac_coef),
        .opnd_i (mac_opnd),
        .res_o  (mac_res),
        .sat_o  (mac_sat)
    );

    // Sequencer next state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        tap_d       = tap_q;
        x_d         = x_q;
        out_d       = out_q;
        sat_d       = sat_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A clear request blocks the input for that cycle.
                in_ready_o = !clear_state_i;
                if (clear_state_i) begin
                    sat_d = 1'b0;
                end else if (in_valid_i) begin
                    x_d     = in_data_i;
                    sec_d   = '0;
                    tap_d   = TAP_B0;
                    state_d = StMac;
                end
            end
            StMac: begin
                if (tap_q == TAP_A2) begin
                    state_d = StWb;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            StWb: begin
                // Section result feeds the next section's input.
                x_d = mac_res;
                if (mac_sat) begin
                    sat_d = 1'b1;
                end
                if (sec_q == SecW'(NUM_SECT - 1)) begin
                    out_d   = mac_res;
                    state_d = StOut;
                end else begin
                    sec_d   = sec_q + SecW'(1);
                    tap_d   = TAP_B0;
                    state_d = StMac;
                end
            end
            StOut: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sec_q     <= '0;
            tap_q     <= '0;
            x_q       <= '0;
            out_q     <= '0;
            sat_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            tap_q     <= tap_d;
            x_q       <= x_d;
            out_q     <= out_d;
            sat_q     <= sat_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Coefficient store, written only while idle with an in-range address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NumCoef); i++) begin
                coef_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            coef_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Per-section delay lines: shifted at write-back, zeroed by an idle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SECT); i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else if (clear_now) begin
            for (int i = 0; i < int'(NUM_SECT); i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else if (state_q == StWb) begin
            x2_q[sec_q] <= x1_q[sec_q];
            x1_q[sec_q] <= x_q;
            y2_q[sec_q] <= y1_q[sec_q];
            y1_q[sec_q] <= mac_res;
        end
    end

endmodule

// File: tb/tb_iir_sos_cascade_tdm.sv
// Bench for the biquad cascade: two sections, randomised streams checked against
// a sample-level arithmetic model of the cascade.
module tb_iir_sos_cascade_tdm;

    localparam int DW = 24;
    localparam int FW = 22;
    localparam int NS = 2;
    localparam int NC = NS * 5;
    localparam int AW = 4;
    localparam longint MaxV = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam longint MinV = -(64'sd1 <<< (DW - 1));
    localparam longint Half = 64'sd1 <<< (FW - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          cfg_err;
    logic          clear_state = 1'b0;
    logic          sat_flag;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // Reference model state.
    longint m_coef [NC];
    longint m_x1 [NS];
    longint m_x2 [NS];
    longint m_y1 [NS];
    longint m_y2 [NS];
    bit     m_sat;

    iir_sos_cascade_tdm #(
        .DW       (DW),
        .FW       (FW),
        .NUM_SECT (NS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_err_o     (cfg_err),
        .clear_state_i (clear_state),
        .sat_flag_o    (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) m_coef[i] = 0;
        for (int s = 0; s < NS; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_sat = 1'b0;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_sat = 1'b0;
    endfunction

    // One whole sample through every section: y = b0x+b1x1+b2x2-a1y1-a2y2.
    function automatic logic [DW-1:0] model_step(input logic [DW-1:0] din);
        longint x, acc, r;
        x = sx(din);
        for (int s = 0; s < NS; s++) begin
            acc = m_coef[s*5] * x + m_coef[s*5+1] * m_x1[s] + m_coef[s*5+2] * m_x2[s]
                - m_coef[s*5+3] * m_y1[s] - m_coef[s*5+4] * m_y2[s];
            r = (acc + Half) >>> FW;
            if (r > MaxV) begin
                r = MaxV; m_sat = 1'b1;
            end else if (r < MinV) begin
                r = MinV; m_sat = 1'b1;
            end
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = r;
            x = r;
        end
        return x[DW-1:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !in_ready; i++) tick();
    endtask

    task automatic cfg_write(input int a, input logic [DW-1:0] d);
        wait_idle();
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (a < NC) m_coef[a] = sx(d);
    endtask

    task automatic program_section(input int s, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                   input logic [DW-1:0] b2, input logic [DW-1:0] a1,
                                   input logic [DW-1:0] a2);
        cfg_write(s * 5 + 0, b0);
        cfg_write(s * 5 + 1, b1);
        cfg_write(s * 5 + 2, b2);
        cfg_write(s * 5 + 3, a1);
        cfg_write(s * 5 + 4, a2);
    endtask

    task automatic program_identity();
        for (int s = 0; s < NS; s++) program_section(s, 24'h400000, '0, '0, '0, '0);
    endtask

    task automatic clear_states();
        wait_idle();
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
        model_clear();
    endtask

    // Transfer one sample and wait (bounded) for its output; lat in cycles.
    task automatic send_sample(input logic [DW-1:0] din, output logic [DW-1:0] dout,
                               output int lat, output bit got);
        int c0;
        got = 1'b0; dout = '0; lat = -1;
        wait_idle();
        in_valid = 1'b1; in_data = din; c0 = cyc;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                dout = out_data; lat = cyc - c0; got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d, exp;
        int lat; bit got, seen;
        program_identity();
        clear_states();
        exp = model_step(24'h123456);
        send_sample(24'h123456, d, lat, got);
        n_chk++; if (!got || d !== exp) begin n_fail++; $display("FAIL rstmid_pre: got %h want %h (seen=%0d)", d, exp, got); end
        wait_idle();
        in_valid = 1'b1; in_data = 24'h0F0F0F;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (30) begin tick(); if (out_valid) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_aborted: got out_valid=%b want 0", seen); end
        program_identity();
        exp = model_step(24'h2468AC);
        send_sample(24'h2468AC, d, lat, got);
        n_chk++; if (!got || d !== exp) begin n_fail++; $display("FAIL rstmid_post: got %h want %h (seen=%0d)", d, exp, got); end
    endtask

    task automatic test_identity();
        logic [DW-1:0] d, exp;
        int lat; bit got;
        program_identity();
        clear_states();
        exp = model_step(24'h200000);
        send_sample(24'h200000, d, lat, got);
        n_chk++; if (!got || d !== 24'h200000) begin n_fail++; $display("FAIL ident_data: got %h want 200000", d); end
        n_chk++; if (lat !== 13) begin n_fail++; $display("FAIL ident_latency: got %0d want 13", lat); end
        exp = model_step(24'hC00000);
        send_sample(24'hC00000, d, lat, got);
        n_chk++; if (!got || d !== exp) begin n_fail++; $display("FAIL ident_neg: got %h want %h", d, exp); end
        n_chk++; if (lat !== 13) begin n_fail++; $display("FAIL ident_latency2: got %0d want 13", lat); end
    endtask

    task automatic test_one_pole();
        logic [DW-1:0] d, ins [4], want [4], mexp;
        int lat; bit got;
        ins  = '{24'h400000, 24'h0, 24'h0, 24'h0};
        want = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
        program_section(0, 24'h400000, '0, '0, 24'hE00000, '0);
        program_section(1, 24'h400000, '0, '0, '0, '0);
        clear_states();
        for (int i = 0; i < 4; i++) begin
            mexp = model_step(ins[i]);
            send_sample(ins[i], d, lat, got);
            n_chk++;
            if (!got || d !== want[i] || d !== mexp) begin
                n_fail++; $display("FAIL one_pole[%0d]: got %h want %h", i, d, want[i]);
            end
        end
    endtask

    task automatic test_round_sat();
        logic [DW-1:0] d;
        int lat; bit got, seen;
        program_section(0, 24'h200000, '0, '0, '0, '0);
        program_section(1, 24'h400000, '0, '0, '0, '0);
        clear_states();
        void'(model_step(24'h000001));
        send_sample(24'h000001, d, lat, got);
        n_chk++; if (!got || d !== 24'h000001) begin n_fail++; $display("FAIL round_half_up: got %h want 000001", d); end
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL round_no_sat: got %b want 0", sat_flag); end
        cfg_write(0, 24'h7FFFFF);
        void'(model_step(24'h7FFFFF));
        send_sample(24'h7FFFFF, d, lat, got);
        n_chk++; if (!got || d !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fffff", d); end
        n_chk++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
        void'(model_step(24'h800000));
        send_sample(24'h800000, d, lat, got);
        n_chk++; if (!got || d !== 24'h800000) begin n_fail++; $display("FAIL sat_neg: got %h want 800000", d); end
        // Clear with a simultaneous input: clear wins, sample is not taken.
        wait_idle();
        clear_state = 1'b1; in_valid = 1'b1; in_data = 24'h111111;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_blocks_in: got %b want 0", in_ready); end
        tick();
        clear_state = 1'b0; in_valid = 1'b0;
        model_clear();
        tick();
        n_chk++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
        seen = 1'b0;
        repeat (20) begin if (out_valid) seen = 1'b1; tick(); end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clear_dropped_in: got out_valid=%b want 0", seen); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp;
        bit got, bad_v, bad_d, bad_r, seen;
        program_identity();
        clear_states();
        out_ready = 1'b0;
        exp = model_step(24'h0ABCDE);
        wait_idle();
        in_valid = 1'b1; in_data = 24'h0ABCDE;
        tick();
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (out_valid) got = 1'b1; else tick();
        end
        n_chk++; if (!got || out_data !== exp) begin n_fail++; $display("FAIL bp_first: got %h want %h", out_data, exp); end
        bad_v = 0; bad_d = 0; bad_r = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            tick();
            if (out_valid !== 1'b1) bad_v = 1;
            if (out_data !== exp) bad_d = 1;
            if (in_ready !== 1'b0) bad_r = 1;
        end
        n_chk++; if (bad_v) begin n_fail++; $display("FAIL bp_valid_hold: got drop want held 1"); end
        n_chk++; if (bad_d) begin n_fail++; $display("FAIL bp_data_stable: got %h want %h", out_data, exp); end
        n_chk++; if (bad_r) begin n_fail++; $display("FAIL bp_in_ready: got 1 want 0"); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle: got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (20) begin tick(); if (out_valid) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_in: got out_valid=%b want 0", seen); end
    endtask

    task automatic test_cfg_err();
        logic [DW-1:0] d, exp;
        int lat; bit got;
        program_identity();
        clear_states();
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfgerr_idle_ok: got %b want 0", cfg_err); end
        exp = model_step(24'h155555);
        wait_idle();
        in_valid = 1'b1; in_data = 24'h155555;
        tick();
        in_valid = 1'b0;
        tick();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 24'h123456;
        tick();
        cfg_we = 1'b0;
        n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfgerr_busy: got %b want 1", cfg_err); end
        tick();
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfgerr_busy_pulse: got %b want 0", cfg_err); end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (out_valid) got = 1'b1; else tick();
        end
        n_chk++; if (!got || out_data !== exp) begin n_fail++; $display("FAIL cfgerr_busy_nowrite: got %h want %h", out_data, exp); end
        wait_idle();
        cfg_we = 1'b1; cfg_addr = 4'd10; cfg_wdata = 24'h7FFFFF;
        tick();
        cfg_we = 1'b0;
        n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfgerr_range: got %b want 1", cfg_err); end
        tick();
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfgerr_range_pulse: got %b want 0", cfg_err); end
        exp = model_step(24'hE54321);
        send_sample(24'hE54321, d, lat, got);
        n_chk++; if (!got || d !== exp) begin n_fail++; $display("FAIL cfgerr_readback: got %h want %h", d, exp); end
    endtask

    task automatic test_cfg_same_cycle();
        logic [DW-1:0] exp;
        bit got;
        program_identity();
        clear_states();
        wait_idle();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 24'h200000;
        in_valid = 1'b1; in_data = 24'h100000;
        m_coef[0] = sx(24'h200000);
        exp = model_step(24'h100000);
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (out_valid) got = 1'b1; else tick();
        end
        n_chk++;
        if (!got || out_data !== exp || out_data !== 24'h080000) begin
            n_fail++; $display("FAIL cfg_same_cycle: got %h want 080000", out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] din, c;
        int last_t, sent, recvd, v;
        localparam int N = 24;
        for (int i = 0; i < NC; i++) begin
            v = int'($urandom_range(0, 32'd4194303)) - 2097152;
            c = DW'(v);
            cfg_write(i, c);
        end
        clear_states();
        last_t = 0; sent = 0; recvd = 0;
        for (int k = 0; k < 2000 && recvd < N; k++) begin
            if (out_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got %h want none", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", recvd, out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                recvd++;
            end
            if (in_ready && sent < N) begin
                din = DW'($urandom);
                in_valid = 1'b1; in_data = din;
                exp_q.push_back(model_step(din));
                if (sent > 0) begin
                    n_chk++;
                    if (cyc - last_t != 14) begin
                        n_fail++; $display("FAIL b2b_spacing: got %0d want 14", cyc - last_t);
                    end
                end
                last_t = cyc; sent++;
            end else if (sent >= N) begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (recvd != N) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", recvd, N); end
        n_chk++; if (sat_flag !== m_sat) begin n_fail++; $display("FAIL b2b_sat_flag: got %b want %b", sat_flag, m_sat); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid();
        test_identity();
        test_one_pole();
        test_round_sat();
        test_backpressure();
        test_cfg_err();
        test_cfg_same_cycle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
